// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for icache/dcache word requests; dcache has fixed priority.
// Latency: completes in the first cycle ramstate==ACCESS under grant (minimum 1 cycle, from IDLE).
// Backpressure: iwait/dwait stay high until ACCESS; the grant is held until completion or request drop.
// Optional feature: define ARB_STARVE_GUARD_EN to bound icache starvation under dcache traffic.
module memory_arbiter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_XFER = 2'd1,
        I_XFER = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t      state_q, state_d;
    logic        grant_d, grant_i;
    logic        access;
    logic        d_done, i_done;
    logic        force_i;
    logic        ren_c, wen_c;
    logic [31:0] addr_c, store_c;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_LIMIT = 3'd4;

    logic [2:0] cnt_q, cnt_d;

    assign force_i = iREN && (cnt_q == STARVE_LIMIT);

    // Counts dcache completions that overtook a pending icache read.
    always_comb begin
        cnt_d = cnt_q;
        if (!iREN || i_done) begin
            cnt_d = 3'd0;
        end else if (d_done && (cnt_q != STARVE_LIMIT)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    assign access = (ramstate == RAM_ACCESS);
    assign iload  = ramload;
    assign dload  = ramload;

    // Grant is recomputed each cycle; dropping the request under an XFER state aborts it.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        case (state_q)
            IDLE: begin
                if (force_i) begin
                    grant_i = 1'b1;
                end else if (dREN || dWEN) begin
                    grant_d = 1'b1;
                end else if (iREN) begin
                    grant_i = 1'b1;
                end
            end
            D_XFER:  grant_d = dREN || dWEN;
            I_XFER:  grant_i = iREN;
            default: ;
        endcase
    end

    assign d_done = grant_d && access;
    assign i_done = grant_i && access;

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (!access) begin
                if (grant_d) begin
                    state_d = D_XFER;
                end else if (grant_i) begin
                    state_d = I_XFER;
                end
            end
        end else if (!(grant_d || grant_i) || access) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ren_c   = 1'b0;
        wen_c   = 1'b0;
        addr_c  = 32'd0;
        store_c = 32'd0;
        if (grant_d) begin
            addr_c  = daddr;
            store_c = dstore;
            wen_c   = dWEN;
            ren_c   = dREN && !dWEN;
        end else if (grant_i) begin
            addr_c = iaddr;
            ren_c  = 1'b1;
        end
    end

    // Gating by nRST makes the RAM interface go quiet asynchronously during reset.
    assign ramREN   = nRST && ren_c;
    assign ramWEN   = nRST && wen_c;
    assign ramaddr  = nRST ? addr_c : 32'd0;
    assign ramstore = nRST ? store_c : 32'd0;
    assign iwait    = !(nRST && i_done);
    assign dwait    = !(nRST && d_done);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
`ifdef ARB_STARVE_GUARD_EN
            cnt_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
`ifdef ARB_STARVE_GUARD_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: cycle vector table plus hand sequences, with a completion scoreboard.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = 2'd0;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int failures = 0;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;

    memory_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] ds;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_iwait;
        logic        e_dwait;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
    } vec_t;

    typedef struct {
        logic        is_i;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] ds,
                                input logic [1:0] rs, input logic [31:0] rl,
                                input logic eiw, input logic edw, input logic eren,
                                input logic ewen, input logic [31:0] eaddr,
                                input logic [31:0] estore);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.ds = ds;
        v.rs = rs; v.rl = rl;
        v.e_iwait = eiw; v.e_dwait = edw; v.e_ren = eren; v.e_wen = ewen;
        v.e_addr = eaddr; v.e_store = estore;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, got, exp);
        end
    endtask

    task automatic sb_check(input int idx);
        exp_t e;
        if (iwait === 1'b0 || dwait === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_completion[%0d] got=iwait%b/dwait%b expected=none",
                         idx, iwait, dwait);
            end else begin
                e = sb.pop_front();
                chk("sb_side_is_i", idx, {31'd0, (iwait === 1'b0)}, {31'd0, e.is_i});
                chk("sb_data", idx, e.is_i ? iload : dload, e.data);
            end
        end
    endtask

    task automatic drive_idle();
        iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
        ramstate = F; ramload = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset values with requests already asserted.
        #2;
        iREN = 1; dREN = 1; daddr = 32'h10; dstore = 32'hFF; iaddr = 32'h20; ramstate = A;
        #1;
        chk("rst_ramREN", 0, {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", 0, {31'd0, ramWEN}, 32'd0);
        chk("rst_ramaddr", 0, ramaddr, 32'd0);
        chk("rst_ramstore", 0, ramstore, 32'd0);
        chk("rst_iwait", 0, {31'd0, iwait}, 32'd1);
        chk("rst_dwait", 0, {31'd0, dwait}, 32'd1);
        drive_idle();
        #5 nRST = 1;

        // Read through BUSY,BUSY,ACCESS.
        vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, B, 0,           1, 1, 1, 0, 32'h40, 0));
        vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, B, 0,           1, 1, 1, 0, 32'h40, 0));
        vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, A, 32'h1234,    0, 1, 1, 0, 32'h40, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, F, 0,                1, 1, 0, 0, 0, 0));
        // dWEN&dREN: write wins; ERROR is only a stall.
        vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, B, 0, 1, 1, 0, 1, 32'h100, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, B, 0, 1, 1, 0, 1, 32'h100, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, E, 0, 1, 1, 0, 1, 32'h100, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, A, 32'h77, 1, 0, 0, 1, 32'h100, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, F, 0,                1, 1, 0, 0, 0, 0));
        // Abort: dREN drops under BUSY, then IDLE grants I with immediate ACCESS.
        vecs.push_back(mk(0, 0, 1, 0, 32'h200, 32'h55, B, 0,     1, 1, 1, 0, 32'h200, 32'h55));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, B, 0,                1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h48, 0, 0, 0, 0, A, 32'h99,      0, 1, 1, 0, 32'h48, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, F, 0,                1, 1, 0, 0, 0, 0));
        // Simultaneous requests: D first, then I on the following cycle.
        vecs.push_back(mk(1, 32'h44, 1, 0, 32'h300, 0, B, 0,     1, 1, 1, 0, 32'h300, 0));
        vecs.push_back(mk(1, 32'h44, 1, 0, 32'h300, 0, B, 0,     1, 1, 1, 0, 32'h300, 0));
        vecs.push_back(mk(1, 32'h44, 1, 0, 32'h300, 0, A, 32'hAAAA, 1, 0, 1, 0, 32'h300, 0));
        vecs.push_back(mk(1, 32'h44, 0, 0, 0, 0, B, 0,           1, 1, 1, 0, 32'h44, 0));
        vecs.push_back(mk(1, 32'h44, 0, 0, 0, 0, B, 0,           1, 1, 1, 0, 32'h44, 0));
        vecs.push_back(mk(1, 32'h44, 0, 0, 0, 0, A, 32'hBBBB,    0, 1, 1, 0, 32'h44, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, F, 0,                1, 1, 0, 0, 0, 0));
        // Single-cycle write from IDLE.
        vecs.push_back(mk(0, 0, 0, 1, 32'h104, 32'hCAFE, A, 32'h5, 1, 0, 0, 1, 32'h104, 32'hCAFE));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, F, 0,                1, 1, 0, 0, 0, 0));

        foreach (vecs[n]) begin
            @(posedge CLK);
            #1;
            iREN = vecs[n].ir; iaddr = vecs[n].ia; dREN = vecs[n].dr; dWEN = vecs[n].dw;
            daddr = vecs[n].da; dstore = vecs[n].ds; ramstate = vecs[n].rs;
            ramload = vecs[n].rl;
            if (!vecs[n].e_iwait) sb.push_back('{1'b1, vecs[n].rl});
            if (!vecs[n].e_dwait) sb.push_back('{1'b0, vecs[n].rl});
            @(negedge CLK);
            chk("iwait", n, {31'd0, iwait}, {31'd0, vecs[n].e_iwait});
            chk("dwait", n, {31'd0, dwait}, {31'd0, vecs[n].e_dwait});
            chk("ramREN", n, {31'd0, ramREN}, {31'd0, vecs[n].e_ren});
            chk("ramWEN", n, {31'd0, ramWEN}, {31'd0, vecs[n].e_wen});
            chk("ramaddr", n, ramaddr, vecs[n].e_addr);
            chk("ramstore", n, ramstore, vecs[n].e_store);
            chk("iload", n, iload, vecs[n].rl);
            chk("dload", n, dload, vecs[n].rl);
            sb_check(n);
        end

        // Both requesters saturated with ACCESS every cycle.
        for (int k = 0; k < 10; k++) begin
            logic exp_i;
            exp_i = GUARD && ((k % 5) == 4);
            @(posedge CLK);
            #1;
            iREN = 1; dREN = 1; dWEN = 0; iaddr = 32'h80; daddr = 32'h90;
            ramstate = A; ramload = 32'hA000 + k;
            sb.push_back('{exp_i, 32'hA000 + k});
            @(negedge CLK);
            chk("starve_addr", k, ramaddr, exp_i ? 32'h80 : 32'h90);
            chk("starve_iwait", k, {31'd0, iwait}, {31'd0, !exp_i});
            sb_check(100 + k);
        end
        @(posedge CLK);
        #1 drive_idle();

        // Reset asserted while an icache read is in flight.
        @(posedge CLK);
        #1;
        iREN = 1; iaddr = 32'h60; ramstate = B;
        @(negedge CLK);
        chk("mid_grant_ramREN", 0, {31'd0, ramREN}, 32'd1);
        @(posedge CLK);
        #1;
        chk("mid_xfer_ramaddr", 0, ramaddr, 32'h60);
        #1 nRST = 0;
        #1;
        chk("mid_rst_ramREN", 0, {31'd0, ramREN}, 32'd0);
        chk("mid_rst_iwait", 0, {31'd0, iwait}, 32'd1);
        chk("mid_rst_dwait", 0, {31'd0, dwait}, 32'd1);
        chk("mid_rst_ramaddr", 0, ramaddr, 32'd0);
        @(negedge CLK);
        #1;
        iREN = 0; dREN = 1; daddr = 32'h70;
        nRST = 1;
        #1;
        chk("post_rst_ramREN", 0, {31'd0, ramREN}, 32'd1);
        chk("post_rst_ramaddr", 0, ramaddr, 32'h70);
        drive_idle();
        @(posedge CLK);
        #1;
        chk("post_rst_idle_ramREN", 0, {31'd0, ramREN}, 32'd0);

        chk("sb_empty", 0, sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
